// File: rtl/booth_r4_mult.sv
// Sequential radix-4 Booth multiplier with a start/busy/done handshake.
// It retires one recoded digit per clock and covers both signed and unsigned operands.
module booth_r4_mult #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int N_DIGITS = WIDTH / 2 + 1;
  localparam int AW       = 2 * WIDTH + 2;
  localparam int BW       = WIDTH + 3;
  localparam int CW       = $clog2(N_DIGITS);
  localparam logic [CW-1:0] LAST_DIGIT = CW'(N_DIGITS - 1);

  typedef enum logic {IDLE, CALC} state_t;

  state_t        state_reg;
  logic [AW-1:0] a_reg;
  logic [AW-1:0] acc_reg;
  logic [BW-1:0] b_reg;
  logic [CW-1:0] cnt_reg;
  logic [AW-1:0] a_ext;
  logic [BW-1:0] b_ext;
  logic [AW-1:0] term;
  logic [AW-1:0] acc_next;

  // Two extra extension bits keep unsigned operands positive when their MSB is set.
  assign a_ext = {{(AW - WIDTH){is_signed & multiplicand[WIDTH-1]}}, multiplicand};
  assign b_ext = {{2{is_signed & multiplier[WIDTH-1]}}, multiplier, 1'b0};

  // a_reg is pre-shifted by 2i and b_reg is pre-shifted right, so the current digit is always b_reg[2:0].
  always_comb begin
    term = '0;
    case (b_reg[2:0])
      3'b001, 3'b010: term = a_reg;
      3'b011:         term = a_reg << 1;
      3'b100:         term = -(a_reg << 1);
      3'b101, 3'b110: term = -a_reg;
      default:        term = '0;
    endcase
    acc_next = acc_reg + term;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      product   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_reg     <= a_ext;
            b_reg     <= b_ext;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            busy      <= 1'b1;
            state_reg <= CALC;
          end
        end
        CALC: begin
          acc_reg <= acc_next;
          a_reg   <= a_reg << 2;
          b_reg   <= b_reg >> 2;
          if (cnt_reg == LAST_DIGIT) begin
            state_reg <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b1;
            product   <= acc_next[2*WIDTH-1:0];
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/booth_r4_mult.md
Name: booth_r4_mult

Overview:
Parametrised sequential radix-4 Booth multiplier. It is the successor to the 8-bit radix-2 sequential multiplier and adds the following:
- configurable operand width
- signed and unsigned modes, selected per operation
- start/busy/done handshake with operands captured at start
- half the iteration count of radix-2

It sits in the datapath as a multi-cycle multiply unit, driven by a simple controller.

Parameters:
WIDTH, 8, operand width in bits; must be even and >= 4
N_DIGITS, WIDTH/2+1, derived localparam (not overridable); number of radix-4 digits processed

Ports:
clk  input  1  clock, rising-edge
rst  input  1  reset, asynchronous, active-high
start  input  1  request a new multiply; sampled only when not busy
is_signed  input  1  1 = two's-complement operands, 0 = unsigned; captured with start
multiplicand  input  WIDTH  operand A; captured with start
multiplier  input  WIDTH  operand B; captured with start
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse; product valid
product  output  2*WIDTH  exact A*B; holds until the next done

Behaviour:
- Reset (rst=1, async): state=IDLE, busy=0, done=0, product=0, and all internal registers cleared. A reset mid-operation aborts it; no done pulse is produced.
- FSM states are IDLE and CALC.
  - IDLE, start=1 at an edge: capture the operands and is_signed, clear the accumulator, digit counter=0, go to CALC, busy=1 from the next cycle.
  - CALC: one digit per edge. After digit N_DIGITS-1 is accumulated (the same edge), go to IDLE, set busy=0, done=1, product=truncated accumulator.
  - done is high for exactly one cycle.
- Latency: start edge to done-high is N_DIGITS edges (8-bit: 5 cycles; 16-bit: 9 cycles). Throughput is one result per N_DIGITS cycles.
- Operand extension, both to WIDTH+2 bits:
  - A and B are sign-extended if is_signed=1.
  - A and B are zero-extended if is_signed=0.
  - B is then given an implicit 0 appended below its LSB.
- Digit i uses bits {B[2i+1], B[2i], B[2i-1]} to recode into {-2,-1,0,+1,+2}:
  - 000/111 -> 0
  - 001/010 -> +A
  - 011 -> +2A
  - 100 -> -2A
  - 101/110 -> -A
  - The selected term is shifted left by 2i and added into an accumulator at least 2*WIDTH+2 bits wide.
- product is the low 2*WIDTH bits of the accumulator. It is exact for all operands in both modes: no overflow and no saturation.
- Handshake:
  - start while busy=1 is ignored. The in-flight operands are unaffected.
  - start in the same cycle that done=1 is accepted (back-to-back; state is IDLE then).
  - Operand inputs may change freely after the start edge.
  - product changes only at a done edge and holds between operations.
- is_signed=0 with the MSB of A or B set must give the unsigned product. This is why the extension to WIDTH+2 bits is required.
- Multiplicand=0 or multiplier=0 still takes the full latency. There is no early termination.

Test Plan:
- WIDTH=8, is_signed=1, A=-3, B=5, start one cycle -> done after 5 cycles; product=16'hFFF1 (-15); busy high for exactly 5 cycles.
- WIDTH=8, is_signed=1, A=-128, B=-128 -> product=16'h4000. Then A=-128, B=127 -> product=16'hC080 (-16256).
- WIDTH=8, is_signed=0, A=8'hFF, B=8'hFF -> product=16'hFE01 (65025). Then A=8'h80, B=8'h02 -> product=16'h0100.
- Issue start A=7, B=6 (signed), then assert start with A=1, B=1 on cycles 2-4 -> a single done pulse with product=42. The mid-op starts are ignored. Re-assert start coincident with done using A=2, B=3 -> the next done gives product=6 five cycles later.
- Assert rst for one cycle, asynchronously (off a clock edge), in cycle 3 of an operation -> busy=0, done=0, product=0 immediately. No done pulse follows. A subsequent start A=-1, B=-1 gives product=1.
- WIDTH=16 instance: 1000 random operand pairs in random modes, back-to-back -> every product matches the reference model. Latency=9 cycles each. Include corner operands 16'h8000, 16'hFFFF, 0 and 1 in both modes.
